// File: rtl/core_commit_pkg.sv
// core_commit_pkg: shared types, default sizing and stack-pointer tap helper for the commit stage
package core_commit_pkg;
  localparam int NUM_EXEC_DEF = 4;
  localparam int NUM_REGS_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int SP_IDX = NUM_REGS_DEF;
  typedef logic [DATA_W_DEF-1:0] reg_word_t;
  typedef logic [$clog2(NUM_EXEC_DEF)-1:0] exec_idx_t;
  typedef logic [$clog2(NUM_REGS_DEF+1)-1:0] reg_idx_t;
  function automatic logic [31:0] sp_tap(input logic [31:0] base, input logic [31:0] offset);
    return (base + offset) & 32'hFFFF_FFFE;
  endfunction
endpackage

// File: rtl/commit_prio_mux.sv
// commit_prio_mux: lowest-index priority select with multi-requester detect
module commit_prio_mux #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic [N-1:0]        en,
  input  logic [N-1:0][W-1:0] data,
  input  logic [W-1:0]        dflt,
  output logic [W-1:0]        sel,
  output logic                multi
);
  // scan downward so the lowest requesting index is the last to overwrite
  always_comb begin
    sel = dflt;
    for (int i = N - 1; i >= 0; i--) sel = en[i] ? data[i] : sel;
  end
  assign multi = |(en & (en - N'(1)));
endmodule

// File: rtl/core_regfile_commit.sv
// core_regfile_commit: merges executer writes into the register file/SP, arbitrates jumps, flags collisions
module core_regfile_commit
  import core_commit_pkg::*;
#(
  parameter int NUM_EXEC = 4,
  parameter int NUM_REGS = 16,
  parameter int DATA_W = 16,
  parameter int JADDR_W = 32,
  parameter int SP_NEG_TAPS = 4,
  parameter int SP_POS_TAPS = 2,
  localparam int EIW = NUM_EXEC > 1 ? $clog2(NUM_EXEC) : 1,
  localparam int RIW = $clog2(NUM_REGS + 1)
) (
  input  logic                                      main_clk,
  input  logic                                      main_rst_n,
  input  logic [NUM_EXEC-1:0][NUM_REGS:0]           wr_en,
  input  logic [NUM_EXEC-1:0][NUM_REGS:0][DATA_W-1:0] wr_data,
  input  logic [NUM_EXEC-1:0]                       jump_req,
  input  logic [NUM_EXEC-1:0][JADDR_W-1:0]          jump_addr,
  input  logic                                      err_clear,
  input  logic                                      snap_req,
  output logic [NUM_REGS-1:0][DATA_W-1:0]           reg_q,
  output logic [DATA_W-1:0]                         sp_q,
  output logic [SP_NEG_TAPS-1:0][DATA_W-1:0]        sp_neg_q,
  output logic [SP_POS_TAPS-1:0][DATA_W-1:0]        sp_pos_q,
  output logic [NUM_REGS:0][DATA_W-1:0]             bypass,
  output logic                                      jump_valid,
  output logic [EIW-1:0]                            jump_index,
  output logic [JADDR_W-1:0]                        jump_target,
  output logic                                      jump_state_q,
  output logic                                      wr_conflict_q,
  output logic [RIW-1:0]                            conflict_reg_q,
  output logic                                      jump_conflict_q,
  output logic [NUM_REGS:0][DATA_W-1:0]             snap_q,
  output logic [15:0]                               commit_cnt_q
);
  logic [NUM_REGS:0][DATA_W-1:0] cur, nxt;
  logic [NUM_REGS:0] multi;
  logic [DATA_W-1:0] sp_nxt;
  logic [SP_NEG_TAPS-1:0][DATA_W-1:0] neg_nxt, neg_rst;
  logic [SP_POS_TAPS-1:0][DATA_W-1:0] pos_nxt, pos_rst;
  logic [RIW-1:0] first_conf;
  logic [NUM_EXEC-1:0][EIW+JADDR_W-1:0] jd;
  logic jmulti;
  assign cur = {sp_q, reg_q};
  assign sp_nxt = {bypass[NUM_REGS][DATA_W-1:1], 1'b0};
  assign nxt = {sp_nxt, bypass[NUM_REGS-1:0]};
  for (genvar r = 0; r <= NUM_REGS; r++) begin : g_reg
    logic [NUM_EXEC-1:0] en;
    logic [NUM_EXEC-1:0][DATA_W-1:0] d;
    for (genvar e = 0; e < NUM_EXEC; e++) begin : g_e
      assign en[e] = wr_en[e][r];
      assign d[e] = wr_data[e][r];
    end
    commit_prio_mux #(.N(NUM_EXEC), .W(DATA_W)) u_mux (
      .en(en), .data(d), .dflt(cur[r]), .sel(bypass[r]), .multi(multi[r])
    );
  end
  for (genvar k = 0; k < SP_NEG_TAPS; k++) begin : g_neg
    assign neg_nxt[k] = DATA_W'(sp_tap(32'(sp_nxt), 32'(-2 * (k + 1))));
    assign neg_rst[k] = DATA_W'(sp_tap(32'd0, 32'(-2 * (k + 1))));
  end
  for (genvar k = 0; k < SP_POS_TAPS; k++) begin : g_pos
    assign pos_nxt[k] = DATA_W'(sp_tap(32'(sp_nxt), 32'(2 * (k + 1))));
    assign pos_rst[k] = DATA_W'(sp_tap(32'd0, 32'(2 * (k + 1))));
  end
  for (genvar e = 0; e < NUM_EXEC; e++) begin : g_jd
    assign jd[e] = {EIW'(e), jump_addr[e]};
  end
  commit_prio_mux #(.N(NUM_EXEC), .W(EIW + JADDR_W)) u_jump (
    .en(jump_req), .data(jd), .dflt('0), .sel({jump_index, jump_target}), .multi(jmulti)
  );
  assign jump_valid = |jump_req;
  // lowest register index that saw more than one writer this cycle
  always_comb begin
    first_conf = '0;
    for (int r = NUM_REGS; r >= 0; r--) first_conf = multi[r] ? RIW'(r) : first_conf;
  end
  // commit merged values, taps and sticky error state; a new conflict beats err_clear
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      reg_q <= '0;
      sp_q <= '0;
      sp_neg_q <= neg_rst;
      sp_pos_q <= pos_rst;
      jump_state_q <= 1'b0;
      wr_conflict_q <= 1'b0;
      conflict_reg_q <= '0;
      jump_conflict_q <= 1'b0;
      snap_q <= '0;
      commit_cnt_q <= '0;
    end else begin
      reg_q <= bypass[NUM_REGS-1:0];
      sp_q <= sp_nxt;
      sp_neg_q <= neg_nxt;
      sp_pos_q <= pos_nxt;
      jump_state_q <= jump_valid;
      wr_conflict_q <= (|multi) | (wr_conflict_q & ~err_clear);
      if ((|multi) && (!wr_conflict_q || err_clear)) conflict_reg_q <= first_conf;
      else if (err_clear) conflict_reg_q <= '0;
      jump_conflict_q <= jmulti | (jump_conflict_q & ~err_clear);
      if (snap_req) snap_q <= nxt;
      if ((|wr_en) && !(&commit_cnt_q)) commit_cnt_q <= commit_cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_core_regfile_commit.sv
// tb_core_regfile_commit: directed vectors with hand-computed expectations
module tb_core_regfile_commit;
  logic main_clk = 1'b0;
  logic main_rst_n = 1'b1;
  logic [3:0][16:0] wr_en;
  logic [3:0][16:0][15:0] wr_data;
  logic [3:0] jump_req;
  logic [3:0][31:0] jump_addr;
  logic err_clear, snap_req;
  logic [15:0][15:0] reg_q;
  logic [15:0] sp_q;
  logic [3:0][15:0] sp_neg_q;
  logic [1:0][15:0] sp_pos_q;
  logic [16:0][15:0] bypass;
  logic jump_valid;
  logic [1:0] jump_index;
  logic [31:0] jump_target;
  logic jump_state_q, wr_conflict_q, jump_conflict_q;
  logic [4:0] conflict_reg_q;
  logic [16:0][15:0] snap_q;
  logic [15:0] commit_cnt_q;
  int n_cmp = 0;
  int n_bad = 0;

  core_regfile_commit dut (
    .main_clk(main_clk), .main_rst_n(main_rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .jump_req(jump_req), .jump_addr(jump_addr), .err_clear(err_clear), .snap_req(snap_req),
    .reg_q(reg_q), .sp_q(sp_q), .sp_neg_q(sp_neg_q), .sp_pos_q(sp_pos_q), .bypass(bypass),
    .jump_valid(jump_valid), .jump_index(jump_index), .jump_target(jump_target),
    .jump_state_q(jump_state_q), .wr_conflict_q(wr_conflict_q), .conflict_reg_q(conflict_reg_q),
    .jump_conflict_q(jump_conflict_q), .snap_q(snap_q), .commit_cnt_q(commit_cnt_q)
  );

  always #5 main_clk = ~main_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle;
    wr_en = '0;
    wr_data = '0;
    jump_req = '0;
    jump_addr = '0;
    err_clear = 1'b0;
    snap_req = 1'b0;
  endtask

  task automatic tick;
    @(posedge main_clk);
    #1;
  endtask

  initial begin
    idle();
    #1 main_rst_n = 1'b0;
    tick();
    tick();
    chk("rst_reg5", 64'(reg_q[5]), 64'h0);
    chk("rst_sp", 64'(sp_q), 64'h0);
    chk("rst_neg", 64'(sp_neg_q), 64'hFFF8_FFFA_FFFC_FFFE);
    chk("rst_pos", 64'(sp_pos_q), 64'h0004_0002);
    chk("rst_cnt", 64'(commit_cnt_q), 64'h0);
    chk("rst_flags", 64'({wr_conflict_q, jump_conflict_q, jump_state_q}), 64'h0);
    main_rst_n = 1'b1;
    tick();
    wr_en[2][5] = 1'b1;
    wr_data[2][5] = 16'h1234;
    #1;
    chk("byp_r5", 64'(bypass[5]), 64'h1234);
    chk("r5_before", 64'(reg_q[5]), 64'h0);
    tick();
    idle();
    chk("r5_commit", 64'(reg_q[5]), 64'h1234);
    chk("cnt1", 64'(commit_cnt_q), 64'd1);
    wr_en[0][16] = 1'b1;
    wr_data[0][16] = 16'h0101;
    tick();
    idle();
    chk("sp_0100", 64'(sp_q), 64'h0100);
    chk("neg0_00fe", 64'(sp_neg_q[0]), 64'h00FE);
    chk("neg3_00f8", 64'(sp_neg_q[3]), 64'h00F8);
    chk("pos1_0104", 64'(sp_pos_q[1]), 64'h0104);
    wr_en[0][16] = 1'b1;
    wr_data[0][16] = 16'h0002;
    tick();
    idle();
    chk("neg1_wrap", 64'(sp_neg_q[1]), 64'hFFFE);
    chk("neg0_zero", 64'(sp_neg_q[0]), 64'h0000);
    chk("pos0_0004", 64'(sp_pos_q[0]), 64'h0004);
    chk("cnt3", 64'(commit_cnt_q), 64'd3);
    wr_en[1][3] = 1'b1;
    wr_data[1][3] = 16'hAAAA;
    wr_en[3][3] = 1'b1;
    wr_data[3][3] = 16'h5555;
    #1;
    chk("byp_r3_low", 64'(bypass[3]), 64'hAAAA);
    tick();
    idle();
    chk("r3_low_wins", 64'(reg_q[3]), 64'hAAAA);
    chk("wconf_set", 64'(wr_conflict_q), 64'h1);
    chk("creg_3", 64'(conflict_reg_q), 64'd3);
    wr_en[0][7] = 1'b1;
    wr_data[0][7] = 16'h1111;
    wr_en[2][7] = 1'b1;
    wr_data[2][7] = 16'h2222;
    wr_en[1][2] = 1'b1;
    wr_data[1][2] = 16'h0022;
    tick();
    idle();
    chk("r7_low_wins", 64'(reg_q[7]), 64'h1111);
    chk("r2_single", 64'(reg_q[2]), 64'h0022);
    chk("creg_keeps3", 64'(conflict_reg_q), 64'd3);
    err_clear = 1'b1;
    tick();
    idle();
    chk("wconf_clr", 64'(wr_conflict_q), 64'h0);
    chk("creg_clr", 64'(conflict_reg_q), 64'd0);
    wr_en[0][9] = 1'b1;
    wr_data[0][9] = 16'h0909;
    wr_en[1][9] = 1'b1;
    wr_data[1][9] = 16'h9090;
    err_clear = 1'b1;
    tick();
    idle();
    chk("clr_vs_new_flag", 64'(wr_conflict_q), 64'h1);
    chk("clr_vs_new_idx", 64'(conflict_reg_q), 64'd9);
    chk("cnt6", 64'(commit_cnt_q), 64'd6);
    jump_req[1] = 1'b1;
    jump_addr[1] = 32'h100;
    jump_req[2] = 1'b1;
    jump_addr[2] = 32'h200;
    #1;
    chk("jvalid", 64'(jump_valid), 64'h1);
    chk("jindex1", 64'(jump_index), 64'd1);
    chk("jtarget100", 64'(jump_target), 64'h100);
    chk("jstate_pre", 64'(jump_state_q), 64'h0);
    tick();
    idle();
    #1;
    chk("jstate_set", 64'(jump_state_q), 64'h1);
    chk("jconf_set", 64'(jump_conflict_q), 64'h1);
    chk("jtarget_none", 64'({jump_valid, jump_target}), 64'h0);
    tick();
    chk("jstate_drop", 64'(jump_state_q), 64'h0);
    jump_req[3] = 1'b1;
    jump_addr[3] = 32'h300;
    err_clear = 1'b1;
    #1;
    chk("jindex3", 64'(jump_index), 64'd3);
    chk("jtarget300", 64'(jump_target), 64'h300);
    tick();
    idle();
    chk("jconf_clr", 64'(jump_conflict_q), 64'h0);
    chk("wconf_clr2", 64'(wr_conflict_q), 64'h0);
    wr_en[0][0] = 1'b1;
    wr_data[0][0] = 16'hBEEF;
    snap_req = 1'b1;
    tick();
    idle();
    chk("snap_r0", 64'(snap_q[0]), 64'hBEEF);
    chk("snap_r5", 64'(snap_q[5]), 64'h1234);
    chk("snap_sp", 64'(snap_q[16]), 64'h0002);
    wr_en[1][0] = 1'b1;
    wr_data[1][0] = 16'hCAFE;
    tick();
    idle();
    chk("r0_cafe", 64'(reg_q[0]), 64'hCAFE);
    chk("snap_hold", 64'(snap_q[0]), 64'hBEEF);
    wr_en[3][16] = 1'b1;
    wr_data[3][16] = 16'h0103;
    snap_req = 1'b1;
    #1;
    chk("byp_sp_raw", 64'(bypass[16]), 64'h0103);
    tick();
    idle();
    chk("snap_sp_even", 64'(snap_q[16]), 64'h0102);
    chk("sp_even", 64'(sp_q), 64'h0102);
    chk("cnt9", 64'(commit_cnt_q), 64'd9);
    wr_en[0][5] = 1'b1;
    wr_data[0][5] = 16'hFFFF;
    #2 main_rst_n = 1'b0;
    #1;
    chk("mid_rst_r5", 64'(reg_q[5]), 64'h0);
    chk("mid_rst_sp", 64'(sp_q), 64'h0);
    chk("mid_rst_neg", 64'(sp_neg_q), 64'hFFF8_FFFA_FFFC_FFFE);
    chk("mid_rst_pos", 64'(sp_pos_q), 64'h0004_0002);
    chk("mid_rst_cnt", 64'(commit_cnt_q), 64'h0);
    chk("mid_rst_snap", 64'(snap_q[0]), 64'h0);
    tick();
    idle();
    main_rst_n = 1'b1;
    tick();
    chk("post_rst_r5", 64'(reg_q[5]), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
